// File: rtl/inert_cmd_seq.sv
// -----------------------------------------------------------------------------
// inert_cmd_seq
// Command sequencer in front of the 16-bit SPI monarch. After a power-up delay
// of 2^STRT_W clocks it writes three configuration words to the inertial
// sensor, then waits for the (synchronized) data-ready interrupt and reads the
// yaw-rate low and high bytes, presenting each sample with a one-cycle strobe.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   INT     in   sensor data-ready, asynchronous, active-high level
//   snd     out  one-cycle pulse starting an SPI transaction
//   cmd     out  [15:0] command word, held until the next snd
//   done    in   SPI transaction complete (level, cleared by next snd)
//   resp    in   [15:0] SPI response, resp[7:0] holds the read byte
//   yaw_rt  out  [15:0] latest yaw rate {high byte, low byte}
//   vld     out  one-cycle strobe, yaw_rt updated this cycle
// -----------------------------------------------------------------------------
module inert_cmd_seq #(
  parameter int          STRT_W   = 16,
  parameter logic [15:0] CMD_CFG0 = 16'h0D02,
  parameter logic [15:0] CMD_CFG1 = 16'h1160,
  parameter logic [15:0] CMD_CFG2 = 16'h1440,
  parameter logic [15:0] CMD_YL   = 16'hA600,
  parameter logic [15:0] CMD_YH   = 16'hA700
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] resp,
  output logic [15:0] yaw_rt,
  output logic        vld
);

  typedef enum logic [2:0] {
    PWRUP    = 3'd0,
    CFG0     = 3'd1,
    CFG1     = 3'd2,
    CFG2     = 3'd3,
    WAIT_INT = 3'd4,
    RD_YL    = 3'd5,
    RD_YH    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [STRT_W-1:0]   cnt_q, cnt_d;
  logic                int_ff1_q, int_ff2_q;
  logic                done_ff_q;
  logic [7:0]          ylo_q, ylo_d;
  logic                snd_q, snd_d;
  logic [15:0]         cmd_q, cmd_d;
  logic [15:0]         yaw_q, yaw_d;
  logic                vld_q, vld_d;
  logic                done_rise_s;

  // A done level left over from the previous transaction must not count,
  // so completion is only the 0->1 transition.
  assign done_rise_s = done & ~done_ff_q;

  assign snd    = snd_q;
  assign cmd    = cmd_q;
  assign yaw_rt = yaw_q;
  assign vld    = vld_q;

  // Two-flop synchronizer for the asynchronous interrupt and done-edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      done_ff_q <= 1'b0;
    end else begin
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      done_ff_q <= done;
    end
  end

  // State, counter, holding register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWRUP;
      cnt_q   <= '0;
      ylo_q   <= 8'h00;
      snd_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      yaw_q   <= 16'h0000;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ylo_q   <= ylo_d;
      snd_q   <= snd_d;
      cmd_q   <= cmd_d;
      yaw_q   <= yaw_d;
      vld_q   <= vld_d;
    end
  end

  // Next-state and output decode; snd/vld are single-cycle by defaulting low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ylo_d   = ylo_q;
    snd_d   = 1'b0;
    cmd_d   = cmd_q;
    yaw_d   = yaw_q;
    vld_d   = 1'b0;
    case (state_q)
      PWRUP: begin
        cnt_d = cnt_q + {{(STRT_W-1){1'b0}}, 1'b1};
        if (&cnt_q) begin
          state_d = CFG0;
          snd_d   = 1'b1;
          cmd_d   = CMD_CFG0;
        end else begin
          state_d = PWRUP;
        end
      end
      CFG0: begin
        if (done_rise_s) begin
          state_d = CFG1;
          snd_d   = 1'b1;
          cmd_d   = CMD_CFG1;
        end else begin
          state_d = CFG0;
        end
      end
      CFG1: begin
        if (done_rise_s) begin
          state_d = CFG2;
          snd_d   = 1'b1;
          cmd_d   = CMD_CFG2;
        end else begin
          state_d = CFG1;
        end
      end
      CFG2: begin
        if (done_rise_s) begin
          state_d = WAIT_INT;
        end else begin
          state_d = CFG2;
        end
      end
      WAIT_INT: begin
        // Level-sensitive: a still-high interrupt immediately starts another read.
        if (int_ff2_q) begin
          state_d = RD_YL;
          snd_d   = 1'b1;
          cmd_d   = CMD_YL;
        end else begin
          state_d = WAIT_INT;
        end
      end
      RD_YL: begin
        if (done_rise_s) begin
          ylo_d   = resp[7:0];
          state_d = RD_YH;
          snd_d   = 1'b1;
          cmd_d   = CMD_YH;
        end else begin
          state_d = RD_YL;
        end
      end
      RD_YH: begin
        if (done_rise_s) begin
          yaw_d   = {resp[7:0], ylo_q};
          vld_d   = 1'b1;
          state_d = WAIT_INT;
        end else begin
          state_d = RD_YH;
        end
      end
      default: begin
        state_d = PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_inert_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_inert_cmd_seq
// Directed bench for inert_cmd_seq with a behavioural SPI monarch model.
// Stimulus pushes the expected command/sample sequence into a queue; a
// monitor pops and compares on every snd or vld the DUT presents.
// -----------------------------------------------------------------------------
module tb_inert_cmd_seq;

  localparam int STRT_W = 4;
  localparam logic [15:0] C_CFG0 = 16'h0D02;
  localparam logic [15:0] C_CFG1 = 16'h1160;
  localparam logic [15:0] C_CFG2 = 16'h1440;
  localparam logic [15:0] C_YL   = 16'hA600;
  localparam logic [15:0] C_YH   = 16'hA700;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT = 1'b0;
  logic        snd, vld, done;
  logic [15:0] cmd, resp, yaw_rt;

  typedef struct packed {
    logic        is_vld;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_vals[$];

  int checks = 0;
  int passes = 0;
  int cyc, drise_cyc;
  int snd_cnt = 0;
  int vld_cnt = 0;
  int last_vld_cyc = 0;
  int gap_base = 0;
  int int_cyc = -1;
  bit gap_mode = 1'b0;
  bit stale = 1'b0;
  logic snd_prev = 1'b0;
  logic vld_prev = 1'b0;

  // model state
  int          tmr;
  bit          busy, clr_pend;
  logic [15:0] cur_cmd;

  always #5 clk = ~clk;

  inert_cmd_seq #(.STRT_W(STRT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .INT    (INT),
    .snd    (snd),
    .cmd    (cmd),
    .done   (done),
    .resp   (resp),
    .yaw_rt (yaw_rt),
    .vld    (vld)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  task automatic push_cmd(logic [15:0] c);
    exp_q.push_back('{is_vld: 1'b0, val: c});
  endtask

  task automatic push_sample(logic [15:0] lo_word, logic [15:0] hi_word);
    rd_vals.push_back(lo_word);
    rd_vals.push_back(hi_word);
    push_cmd(C_YL);
    push_cmd(C_YH);
    exp_q.push_back('{is_vld: 1'b1, val: {hi_word[7:0], lo_word[7:0]}});
  endtask

  task automatic wait_snd(int n, int budget);
    int k = 0;
    while (snd_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (snd_cnt < n) begin
      checks++;
      $display("FAIL wait_snd: got %0d snd pulses, expected %0d", snd_cnt, n);
    end
  endtask

  task automatic wait_vld(int n, int budget);
    int k = 0;
    while (vld_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (vld_cnt < n) begin
      checks++;
      $display("FAIL wait_vld: got %0d vld strobes, expected %0d", vld_cnt, n);
    end
  endtask

  task automatic int_pulse(int n);
    INT = 1'b1;
    int_cyc = cyc;
    repeat (n) @(negedge clk);
    INT = 1'b0;
  endtask

  // SPI monarch model: done rises 40 clocks after snd; optional stale done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      resp      <= 16'h0000;
      busy      <= 1'b0;
      clr_pend  <= 1'b0;
      tmr       <= 0;
      cyc       <= 0;
      drise_cyc <= 0;
      cur_cmd   <= 16'h0000;
    end else begin
      cyc <= cyc + 1;
      if (snd) begin
        busy    <= 1'b1;
        tmr     <= 0;
        cur_cmd <= cmd;
        if (stale) clr_pend <= 1'b1;
        else done <= 1'b0;
      end else begin
        if (clr_pend) begin
          done     <= 1'b0;
          clr_pend <= 1'b0;
        end
        if (busy) begin
          if (tmr == 39) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            drise_cyc <= cyc + 1;
            if (cur_cmd == C_YL || cur_cmd == C_YH)
              resp <= (rd_vals.size() > 0) ? rd_vals.pop_front() : 16'hDEAD;
          end else begin
            tmr <= tmr + 1;
          end
        end
      end
    end
  end

  // Monitor: compares every snd/vld against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (snd) begin
          check("snd_width", {31'd0, snd_prev}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_snd: got cmd %h, expected no snd", cmd);
          end else begin
            e = exp_q.pop_front();
            check("cmd", {15'd0, 1'b0, cmd}, {15'd0, e.is_vld, e.val});
            if (!e.is_vld && e.val == C_CFG0)
              check("pwrup_delay", cyc, 32'd16);
            if (!e.is_vld && (e.val == C_CFG1 || e.val == C_CFG2))
              check("cfg_after_done", cyc, drise_cyc + 1);
            if (!e.is_vld && e.val == C_YL && int_cyc >= 0) begin
              check("int_to_snd", cyc, int_cyc + 3);
              int_cyc = -1;
            end
            if (gap_mode && !e.is_vld && e.val == C_YL && last_vld_cyc > gap_base)
              check("vld_snd_gap", cyc - last_vld_cyc, 32'd1);
          end
          snd_cnt++;
        end
        if (vld) begin
          check("vld_width", {31'd0, vld_prev}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_vld: got yaw_rt %h, expected no vld", yaw_rt);
          end else begin
            e = exp_q.pop_front();
            check("yaw_rt", {15'd0, 1'b1, yaw_rt}, {15'd0, e.is_vld, e.val});
          end
          vld_cnt++;
          last_vld_cyc = cyc;
        end
      end
      snd_prev = snd;
      vld_prev = vld;
    end
  end

  // Directed stimulus.
  initial begin
    int base;
    int vbase;
    repeat (3) @(negedge clk);
    check("rst_snd", {31'd0, snd}, 32'd0);
    check("rst_cmd", {16'd0, cmd}, 32'd0);
    check("rst_yaw", {16'd0, yaw_rt}, 32'd0);
    check("rst_vld", {31'd0, vld}, 32'd0);

    // power-up and configuration
    push_cmd(C_CFG0);
    push_cmd(C_CFG1);
    push_cmd(C_CFG2);
    rst_n = 1'b1;
    wait_snd(3, 400);
    repeat (60) @(negedge clk);
    check("cfg_snd_count", snd_cnt, 32'd3);
    check("cfg_no_vld", vld_cnt, 32'd0);

    // single sample
    push_sample(16'h00CD, 16'h00AB);
    int_pulse(5);
    wait_vld(1, 300);

    // continuous interrupt: back-to-back samples, upper resp byte ignored
    base = snd_cnt;
    vbase = vld_cnt;
    gap_base = cyc;
    gap_mode = 1'b1;
    push_sample(16'hFF34, 16'hEE12);
    push_sample(16'h7778, 16'h6656);
    push_sample(16'h110F, 16'h229A);
    INT = 1'b1;
    int_cyc = cyc;
    wait_snd(base + 6, 600);
    INT = 1'b0;
    wait_vld(vbase + 3, 300);
    gap_mode = 1'b0;
    repeat (60) @(negedge clk);
    check("cont_snd_count", snd_cnt, base + 6);

    // stale done held across the next snd
    base = snd_cnt;
    stale = 1'b1;
    push_sample(16'h0021, 16'h0043);
    int_pulse(5);
    wait_vld(vld_cnt + 1, 300);
    repeat (60) @(negedge clk);
    check("stale_snd_count", snd_cnt, base + 2);
    stale = 1'b0;

    // interrupt toggled during RD_YH is ignored
    base = snd_cnt;
    vbase = vld_cnt;
    push_sample(16'h0088, 16'h0077);
    int_pulse(5);
    wait_snd(base + 2, 300);
    repeat (5) @(negedge clk);
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
    wait_vld(vbase + 1, 300);
    repeat (60) @(negedge clk);
    check("rdyh_int_snd_count", snd_cnt, base + 2);

    // reset in the middle of RD_YL
    base = snd_cnt;
    push_cmd(C_YL);
    int_pulse(5);
    wait_snd(base + 1, 300);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_snd", {31'd0, snd}, 32'd0);
    check("midrst_vld", {31'd0, vld}, 32'd0);
    check("midrst_yaw", {16'd0, yaw_rt}, 32'd0);
    check("midrst_cmd", {16'd0, cmd}, 32'd0);
    rd_vals.delete();
    @(negedge clk);
    @(negedge clk);
    base = snd_cnt;
    vbase = vld_cnt;
    push_cmd(C_CFG0);
    push_cmd(C_CFG1);
    push_cmd(C_CFG2);
    rst_n = 1'b1;
    // interrupt activity during CFG1 has no effect
    wait_snd(base + 2, 300);
    repeat (3) @(negedge clk);
    INT = 1'b1;
    repeat (3) @(negedge clk);
    INT = 1'b0;
    wait_snd(base + 3, 300);
    repeat (60) @(negedge clk);
    check("recfg_snd_count", snd_cnt, base + 3);
    check("recfg_no_vld", vld_cnt, vbase);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
